// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Index width for n items; never narrower than one bit so N_REQ=1 still has a grant port.
  function automatic int unsigned clog2(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ  = uart_pkg::N_REQ_DEF,
  parameter int unsigned DATA_W = uart_pkg::DATA_W_DEF
) ();
  import uart_pkg::*;

  localparam int unsigned GW = clog2(N_REQ);

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        lock_i;
  logic [N_REQ-1:0]        ack_o;
  logic [N_REQ-1:0]        err_o;
  logic [GW-1:0]           grant_o;
  logic                    busy_o;
  logic [DATA_W-1:0]       uart_tx_data;
  logic                    uart_tx_req;
  logic                    uart_tx_ack;

  // Arbiter view.
  modport slave (
    input  req_i, data_i, lock_i, uart_tx_ack,
    output ack_o, err_o, grant_o, busy_o, uart_tx_data, uart_tx_req
  );

  // Requesters plus UART transmitter view.
  modport master (
    output req_i, data_i, lock_i, uart_tx_ack,
    input  ack_o, err_o, grant_o, busy_o, uart_tx_data, uart_tx_req
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin search: first set request above last_grant, wrapping to 0.
module uart_rr_arbiter #(
  parameter int unsigned N_REQ = uart_pkg::N_REQ_DEF
) (
  input  logic [N_REQ-1:0]                   req,
  input  logic [uart_pkg::clog2(N_REQ)-1:0]  last_grant,
  output logic [uart_pkg::clog2(N_REQ)-1:0]  winner_c,
  output logic                               valid_c
);
  import uart_pkg::*;

  localparam int unsigned GW = clog2(N_REQ);

  logic [GW-1:0] idx;

  // Scan offsets 1..N_REQ from last_grant; the first hit wins.
  always_comb begin
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = GW'((32'(last_grant) + off) % N_REQ);
      if (!valid_c && req[idx]) begin
        winner_c = idx;
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte sources with lock and timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = uart_pkg::N_REQ_DEF,
  parameter int unsigned DATA_W  = uart_pkg::DATA_W_DEF,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             inclk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  import uart_pkg::*;

  localparam int unsigned   GW       = clog2(N_REQ);
  localparam int unsigned   CW       = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_req_q, tx_req_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              lock_flag_q, lock_flag_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [GW-1:0]     rr_win_c;
  logic              rr_valid_c;
  logic [GW-1:0]     win_c;
  logic              lock_hit_c;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (bus.req_i),
    .last_grant (last_grant_q),
    .winner_c   (rr_win_c),
    .valid_c    (rr_valid_c)
  );

  // A locked owner that still requests keeps the UART.
  assign lock_hit_c = lock_flag_q & bus.req_i[last_grant_q];

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    tx_req_d     = tx_req_q;
    ack_d        = '0;
    err_d        = '0;
    lock_flag_d  = lock_flag_q;
    cnt_d        = cnt_q;
    win_c        = rr_win_c;

    unique case (state_q)
      IDLE: begin
        if (lock_flag_q && !lock_hit_c) lock_flag_d = 1'b0;
        win_c = lock_hit_c ? last_grant_q : rr_win_c;
        if (lock_hit_c || rr_valid_c) begin
          grant_d  = win_c;
          data_d   = bus.data_i[32'(win_c)*DATA_W +: DATA_W];
          tx_req_d = 1'b1;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Ack wins over a simultaneous terminal count.
        if (bus.uart_tx_ack) begin
          tx_req_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          lock_flag_d    = bus.lock_i[grant_q];
          last_grant_d   = grant_q;
          state_d        = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          tx_req_d       = 1'b0;
          err_d[grant_q] = 1'b1;
          lock_flag_d    = 1'b0;
          last_grant_d   = grant_q;
          state_d        = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Four-phase: wait for the UART to drop ack before a new request.
        if (!bus.uart_tx_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer without pulses.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      data_q       <= '0;
      tx_req_q     <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      lock_flag_q  <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      tx_req_q     <= tx_req_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      lock_flag_q  <= lock_flag_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack_o        = ack_q;
  assign bus.err_o        = err_q;
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = busy_q;
  assign bus.uart_tx_data = data_q;
  assign bus.uart_tx_req  = tx_req_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus corner-case sequences.
module tb_uart_tx_arbiter;

  logic inclk = 1'b0;
  logic rst;

  always #5 inclk = ~inclk;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .inclk (inclk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
    int          ack_dly;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  vec_t  tbl [15];
  exp_t  sb  [$];
  int    n_vec = 0;
  int    n_err = 0;
  string tag   = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
    end
  endtask

  // Wait (bounded) for uart_tx_req, then pop the scoreboard and compare grant/data.
  task automatic wait_pop(output logic [1:0] g);
    int   n;
    exp_t e;
    n = 0;
    g = '0;
    while (!bus.uart_tx_req && n < 64) begin
      @(posedge inclk); #1;
      n++;
    end
    check("tx_req_seen", 32'(bus.uart_tx_req), 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s/sb_empty: got request with no expectation, want a queued entry", tag);
      return;
    end
    e = sb.pop_front();
    g = e.grant;
    check("grant", 32'(bus.grant_o), 32'(e.grant));
    check("tx_data", 32'(bus.uart_tx_data), 32'(e.data));
  endtask

  // UART model: ack after ack_dly cycles, check the one-cycle ack_o pulse, release.
  task automatic serve(input int ack_dly);
    logic [1:0] g;
    logic [3:0] one_hot;
    wait_pop(g);
    one_hot = 4'b0001 << g;
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge inclk); #1;
      check("req_held", 32'(bus.uart_tx_req), 32'd1);
    end
    bus.uart_tx_ack = 1'b1;
    @(posedge inclk); #1;
    check("ack_pulse", 32'(bus.ack_o), 32'(one_hot));
    check("no_err", 32'(bus.err_o), 32'd0);
    check("req_drop", 32'(bus.uart_tx_req), 32'd0);
    bus.uart_tx_ack = 1'b0;
    @(posedge inclk); #1;
    check("ack_one_cycle", 32'(bus.ack_o), 32'd0);
    check("idle_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] g;
    int hi, bad;

    rst = 1'b1;
    bus.req_i = '0;
    bus.data_i = '0;
    bus.lock_i = '0;
    bus.uart_tx_ack = 1'b0;

    //            req      lock     data           grant  byte   ack_dly
    tbl[0]  = '{4'b1111, 4'b0000, 32'h13121110, 2'd0, 8'h10, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 32'h13121110, 2'd1, 8'h11, 1};
    tbl[2]  = '{4'b1111, 4'b0000, 32'h13121110, 2'd2, 8'h12, 2};
    tbl[3]  = '{4'b1111, 4'b0000, 32'h13121110, 2'd3, 8'h13, 3};
    tbl[4]  = '{4'b1111, 4'b0000, 32'h13121110, 2'd0, 8'h10, 0};
    tbl[5]  = '{4'b0101, 4'b0100, 32'hD4C3B2A1, 2'd2, 8'hC3, 1};
    tbl[6]  = '{4'b0101, 4'b0100, 32'hD4C3B2A1, 2'd2, 8'hC3, 0};
    tbl[7]  = '{4'b0101, 4'b0100, 32'hD4C3B2A1, 2'd2, 8'hC3, 2};
    tbl[8]  = '{4'b0001, 4'b0000, 32'hD4C3B2A1, 2'd0, 8'hA1, 0};
    tbl[9]  = '{4'b1010, 4'b0000, 32'hD4C3B2A1, 2'd1, 8'hB2, 1};
    tbl[10] = '{4'b1000, 4'b0000, 32'hD4C3B2A1, 2'd3, 8'hD4, 3};
    tbl[11] = '{4'b0110, 4'b0000, 32'hD4C3B2A1, 2'd1, 8'hB2, 0};
    tbl[12] = '{4'b1001, 4'b1000, 32'hD4C3B2A1, 2'd3, 8'hD4, 1};
    tbl[13] = '{4'b1001, 4'b0000, 32'hD4C3B2A1, 2'd3, 8'hD4, 0};
    tbl[14] = '{4'b0011, 4'b0000, 32'hD4C3B2A1, 2'd0, 8'hA1, 2};

    // Reset values.
    tag = "reset";
    repeat (3) @(posedge inclk);
    #1;
    check("tx_req", 32'(bus.uart_tx_req), 32'd0);
    check("tx_data", 32'(bus.uart_tx_data), 32'd0);
    check("ack", 32'(bus.ack_o), 32'd0);
    check("err", 32'(bus.err_o), 32'd0);
    check("grant", 32'(bus.grant_o), 32'd0);
    check("busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;

    // Round-robin and lock vectors.
    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("vec%0d", i);
      bus.req_i  = tbl[i].req;
      bus.lock_i = tbl[i].lock;
      bus.data_i = tbl[i].data;
      sb.push_back('{tbl[i].exp_grant, tbl[i].exp_data});
      serve(tbl[i].ack_dly);
    end

    // Single request: one-cycle latency to uart_tx_req.
    tag = "single";
    bus.req_i  = 4'b0001;
    bus.lock_i = 4'b0000;
    bus.data_i = 32'h000000A5;
    sb.push_back('{2'd0, 8'hA5});
    @(posedge inclk); #1;
    check("latency", 32'(bus.uart_tx_req), 32'd1);
    serve(2);
    bus.req_i = 4'b0000;

    // Timeout with input changes during REQ ignored.
    tag = "timeout";
    bus.req_i  = 4'b0100;
    bus.data_i = 32'h005C0000;
    sb.push_back('{2'd2, 8'h5C});
    wait_pop(g);
    bus.req_i  = 4'b1111;
    bus.data_i = 32'hFFFFFFFF;
    hi = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge inclk); #1;
      if (!bus.uart_tx_req) break;
      hi++;
      if (bus.uart_tx_data !== 8'h5C || bus.grant_o !== 2'd2) bad++;
    end
    check("req_cycles", 32'(hi), 32'd16);
    check("stable_while_req", 32'(bad), 32'd0);
    check("err_pulse", 32'(bus.err_o), 32'h4);
    check("no_ack", 32'(bus.ack_o), 32'd0);
    bus.req_i = 4'b0000;
    @(posedge inclk); #1;
    check("idle_after", 32'(bus.busy_o), 32'd0);
    check("err_one_cycle", 32'(bus.err_o), 32'd0);

    // Ack held high: no new request until it falls.
    tag = "hold_ack";
    bus.req_i  = 4'b0001;
    bus.data_i = 32'h0000003C;
    sb.push_back('{2'd0, 8'h3C});
    wait_pop(g);
    bus.uart_tx_ack = 1'b1;
    @(posedge inclk); #1;
    check("ack_pulse", 32'(bus.ack_o), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge inclk); #1;
      check("no_req_while_ack", 32'(bus.uart_tx_req), 32'd0);
      check("busy_while_ack", 32'(bus.busy_o), 32'd1);
    end
    bus.uart_tx_ack = 1'b0;
    @(posedge inclk); #1;
    check("no_req_at_fall", 32'(bus.uart_tx_req), 32'd0);
    sb.push_back('{2'd0, 8'h3C});
    @(posedge inclk); #1;
    check("req_after_fall", 32'(bus.uart_tx_req), 32'd1);
    wait_pop(g);

    // Reset mid-REQ: asynchronous clear, no pulses, requester 0 first afterwards.
    tag = "reset_mid";
    #2 rst = 1'b1;
    #1;
    check("tx_req", 32'(bus.uart_tx_req), 32'd0);
    check("tx_data", 32'(bus.uart_tx_data), 32'd0);
    check("grant", 32'(bus.grant_o), 32'd0);
    check("busy", 32'(bus.busy_o), 32'd0);
    check("ack", 32'(bus.ack_o), 32'd0);
    check("err", 32'(bus.err_o), 32'd0);
    bus.req_i  = 4'b1111;
    bus.data_i = 32'h13121110;
    for (int i = 0; i < 2; i++) begin
      @(posedge inclk); #1;
      check("no_pulse", 32'({bus.ack_o, bus.err_o}), 32'd0);
      check("held_req", 32'(bus.uart_tx_req), 32'd0);
    end
    rst = 1'b0;
    sb.push_back('{2'd0, 8'h10});
    serve(1);
    bus.req_i = 4'b0000;

    tag = "end";
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
